tx_serializer: RTL
==================

TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the parallel word width (legal 2..32).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-004 SHALL have port in_data, input, DATA_WIDTH, meaning the parallel word to transmit.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-007 SHALL have port ser_data, output, 1, meaning the serial bit that drives the transmitter data input.
REQ-008 SHALL have port mod_en, output, 1, meaning the modulator enable that drives the transmitter control input.
REQ-009 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-010 SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the last frame bit.

Function
REQ-011 SHALL use FSM states IDLE, START, DATA, PARITY and STOP, each emitting one bit per clk cycle.
REQ-012 SHALL accept a word on any rising edge with in_valid=1 and in_ready=1, capture it into a shift register, and enter START on the next cycle (latency 1).
REQ-013 SHALL drive in_ready=1 in IDLE and in STOP, and in_ready=0 in all other states.
REQ-014 In START, SHALL drive ser_data=1 for exactly one cycle.
REQ-015 In DATA, SHALL emit DATA_WIDTH bits LSB-first, one per cycle, using a bit counter that counts 0..DATA_WIDTH-1; on the terminal count it moves to PARITY if enabled, else to STOP.
REQ-016 In STOP, SHALL drive ser_data=0 for exactly one cycle.
REQ-017 When a word is accepted in STOP, SHALL go to START with no idle gap (back-to-back frames); otherwise SHALL go to IDLE.
REQ-018 SHALL drive mod_en=1 and busy=1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-019 In IDLE, SHALL drive ser_data=0.
REQ-020 SHALL pulse frame_done=1 in the cycle after STOP, whether that cycle is IDLE or START of the next frame.
REQ-021 SHALL ignore in_data and in_valid while in_ready=0; the captured word SHALL NOT change mid-frame.
REQ-022 SHALL make frame length 2+DATA_WIDTH cycles without parity and 3+DATA_WIDTH cycles with parity.

Reset
REQ-023 When rst_n=0 at a rising edge, SHALL set state to IDLE, clear the shift register and bit counter, and set ser_data=0, mod_en=0, busy=0, frame_done=0 and in_ready=1 (after release).
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; no STOP bit and no frame_done SHALL be emitted.
REQ-025 A word presented with in_valid=1 in the same cycle as rst_n=0 SHALL NOT be accepted.

Configuration
REQ-026 SHALL compile in the PARITY state only when macro TX_SERIALIZER_PARITY_EN is defined; that state drives ser_data to the even-parity bit (XOR of the captured word) for one cycle between DATA and STOP.
REQ-027 When TX_SERIALIZER_PARITY_EN is not defined, SHALL omit the PARITY state and parity logic entirely, and DATA SHALL go directly to STOP.

Structure
REQ-028 SHALL place the state enum type, START_BIT=1'b1 and STOP_BIT=1'b0 constants in shared package tx_ser_pkg.
REQ-029 SHALL instantiate exactly one sub-module, tx_bit_counter (load, enable, terminal-count output, parameterised by DATA_WIDTH).

Verification
REQ-030 Single word: reset, then in_data=8'hA5 with in_valid for 1 cycle -> ser_data sequence 1,1,0,1,0,0,1,0,1,0 starting the next cycle; mod_en=1 for exactly 10 cycles; frame_done pulses once.
REQ-031 Back-to-back: in_valid held high with 8'h01 then 8'hFF -> second frame's START immediately follows the first frame's STOP; mod_en never drops; frame_done pulses at the first cycle of frame 2.
REQ-032 Stall: toggle in_data during DATA with in_valid=1 -> the transmitted bits match the originally accepted word, and in_ready=0 throughout.
REQ-033 Mid-frame reset: rst_n=0 during the 4th data bit -> next cycle ser_data=0, mod_en=0, busy=0, in_ready=1, and no frame_done.
REQ-034 Parity (TX_SERIALIZER_PARITY_EN defined): 8'h07 -> parity bit 1 after the data bits; 8'h03 -> parity bit 0; frame length 11 cycles.
REQ-035 Idle: in_valid=0 for 20 cycles after reset -> ser_data=0, mod_en=0 and frame_done=0 constantly.

Source files
------------

// File: rtl/tx_ser_pkg.sv
// Shared types and constants for the tx_serializer slice.
// The PARITY state exists only when TX_SERIALIZER_PARITY_EN is defined.
package tx_ser_pkg;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef TX_SERIALIZER_PARITY_EN
    , PARITY
`endif
  } state_e;

endpackage

// File: rtl/tx_bit_counter.sv
// Data-bit counter for the serializer: counts 0..DATA_WIDTH-1.
// load clears, en advances, tc_o flags the last data bit.
module tx_bit_counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load has priority over advance.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/tx_serializer.sv
// Parallel-to-serial frame transmitter: START, DATA (LSB first), STOP.
// Define TX_SERIALIZER_PARITY_EN to add an even-parity bit after DATA.
module tx_serializer
  import tx_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_data,
  output logic                  mod_en,
  output logic                  busy,
  output logic                  frame_done
);

  state_e                  state_q;
  state_e                  state_d;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic                    done_q;
  logic                    accept;
  logic                    tc;
  logic                    cnt_en;
`ifdef TX_SERIALIZER_PARITY_EN
  logic                    par_q;
  logic                    par_d;
`endif

  assign accept     = in_valid & in_ready;
  assign cnt_en     = (state_q == DATA);
  assign frame_done = done_q;

  tx_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .en_i   (cnt_en),
    .tc_o   (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: state_d = DATA;
`ifdef TX_SERIALIZER_PARITY_EN
      DATA:   if (tc) state_d = PARITY;
      PARITY: state_d = STOP;
`else
      DATA:  if (tc) state_d = STOP;
`endif
      STOP:  state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    ser_data = 1'b0;
    mod_en   = 1'b1;
    busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        mod_en   = 1'b0;
        busy     = 1'b0;
      end
      START: ser_data = START_BIT;
      DATA:  ser_data = shift_q[0];
`ifdef TX_SERIALIZER_PARITY_EN
      PARITY: ser_data = par_q;
`endif
      STOP: begin
        in_ready = 1'b1;
        ser_data = STOP_BIT;
      end
      default: begin
        mod_en = 1'b0;
        busy   = 1'b0;
      end
    endcase
  end

  // Shift register: capture on accept, shift right while in DATA.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = in_data;
    end else if (state_q == DATA) begin
      shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
    end
  end

`ifdef TX_SERIALIZER_PARITY_EN
  // Parity is latched with the word since shifting destroys it.
  always_comb begin
    par_d = par_q;
    if (accept) par_d = ^in_data;
  end
`endif

  // Datapath and frame_done registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      done_q  <= 1'b0;
`ifdef TX_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      done_q  <= (state_q == STOP);
`ifdef TX_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
